// File: rtl/mcpu_pkg.sv
// mcpu_pkg: shared opcodes, FSM state encoding and default widths for the MCPU ALU slice
package mcpu_pkg;
  localparam int CMD_SIZE  = 2;
  localparam int WORD_SIZE = 8;
  localparam logic [CMD_SIZE-1:0] OP_AND = 2'd0;
  localparam logic [CMD_SIZE-1:0] OP_OR  = 2'd1;
  localparam logic [CMD_SIZE-1:0] OP_XOR = 2'd2;
  localparam logic [CMD_SIZE-1:0] OP_ADD = 2'd3;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;
endpackage

// File: rtl/mcpu_alu_arbiter_alu.sv
// MCPU_Alu: combinational ALU (AND/OR/XOR/ADD) with carry-out of ADD as overflow
module MCPU_Alu
  import mcpu_pkg::*;
#(
  parameter int CMD_SIZE  = mcpu_pkg::CMD_SIZE,
  parameter int WORD_SIZE = mcpu_pkg::WORD_SIZE
) (
  input  logic [CMD_SIZE-1:0]  cmd,
  input  logic [WORD_SIZE-1:0] r1,
  input  logic [WORD_SIZE-1:0] r2,
  output logic [WORD_SIZE-1:0] out,
  output logic                 overflow
);
  logic [WORD_SIZE:0] sum;
  // Result select; ADD wraps and its carry becomes overflow
  always_comb begin
    sum      = {1'b0, r1} + {1'b0, r2};
    out      = cmd == OP_AND ? r1 & r2 :
               cmd == OP_OR  ? r1 | r2 :
               cmd == OP_XOR ? r1 ^ r2 : sum[WORD_SIZE-1:0];
    overflow = cmd == OP_ADD && sum[WORD_SIZE];
  end
endmodule

// File: rtl/mcpu_alu_arbiter.sv
// mcpu_alu_arbiter: shares one MCPU_Alu between two requesters; MCPU_ALU_ARB_RR_EN selects round-robin
module mcpu_alu_arbiter
  import mcpu_pkg::*;
#(
  parameter int CMD_SIZE  = mcpu_pkg::CMD_SIZE,
  parameter int WORD_SIZE = mcpu_pkg::WORD_SIZE,
  parameter int CNT_SIZE  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [CMD_SIZE-1:0]  req0_op,
  input  logic [WORD_SIZE-1:0] req0_a,
  input  logic [WORD_SIZE-1:0] req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [CMD_SIZE-1:0]  req1_op,
  input  logic [WORD_SIZE-1:0] req1_a,
  input  logic [WORD_SIZE-1:0] req1_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [WORD_SIZE-1:0] rsp_data,
  output logic                 rsp_ovf,
  output logic [CNT_SIZE-1:0]  op_count
);
  state_t               state;
  logic [CMD_SIZE-1:0]  op_q;
  logic [WORD_SIZE-1:0] a_q, b_q, alu_out;
  logic                 alu_ovf, accept, win;
`ifdef MCPU_ALU_ARB_RR_EN
  logic last_grant;
  // Contention alternates away from the previous winner
  always_comb win = req0_valid && req1_valid ? !last_grant : req1_valid;
`else
  // Requester 0 wins any contention
  always_comb win = !req0_valid;
`endif
  // Ready is gated by rst_n so nothing is accepted while reset is held
  always_comb begin
    accept     = rst_n && state == ST_IDLE && (req0_valid || req1_valid);
    req0_ready = accept && !win;
    req1_ready = accept && win;
  end
  MCPU_Alu #(.CMD_SIZE(CMD_SIZE), .WORD_SIZE(WORD_SIZE)) alu_u (
    .cmd(op_q), .r1(a_q), .r2(b_q), .out(alu_out), .overflow(alu_ovf)
  );
  // Accept -> compute -> hold response until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_ovf   <= 1'b0;
      op_count  <= '0;
`ifdef MCPU_ALU_ARB_RR_EN
      last_grant <= 1'b1;
`endif
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          op_q   <= win ? req1_op : req0_op;
          a_q    <= win ? req1_a : req0_a;
          b_q    <= win ? req1_b : req0_b;
          rsp_id <= win;
          state  <= ST_EXEC;
`ifdef MCPU_ALU_ARB_RR_EN
          last_grant <= win;
`endif
        end
        ST_EXEC: begin
          rsp_data  <= alu_out;
          rsp_ovf   <= alu_ovf;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        default: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          op_count  <= &op_count ? op_count : op_count + 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mcpu_alu_arbiter.sv
// tb_mcpu_alu_arbiter: directed self-checking bench for mcpu_alu_arbiter
module tb_mcpu_alu_arbiter;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b1;
  logic [1:0] req0_op = '0, req1_op = '0;
  logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic       req0_ready, req1_ready, rsp_valid, rsp_id, rsp_ovf;
  logic [7:0] rsp_data;
  logic [15:0] op_count;
  logic       s_r0, s_r1, s_valid, s_id, s_ovf;
  logic [7:0] s_data;
  logic [1:0] sat_cnt;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  mcpu_alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ovf(rsp_ovf),
    .op_count(op_count)
  );

  mcpu_alu_arbiter #(.CNT_SIZE(2)) sat_u (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(s_r0), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(s_r1), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(s_valid), .rsp_ready(rsp_ready), .rsp_id(s_id), .rsp_data(s_data), .rsp_ovf(s_ovf),
    .op_count(sat_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic single(input logic id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] edata, input logic eovf, input int stall, input logic [15:0] ecnt);
    logic [7:0] held;
    @(negedge clk);
    if (id) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    else begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    rsp_ready = (stall == 0);
    #1 chk("ready_grant", {30'd0, req1_ready, req0_ready}, id ? 2 : 1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("exec_no_rsp", rsp_valid, 0);
    @(negedge clk);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, id);
    chk("rsp_data", rsp_data, edata);
    chk("rsp_ovf", rsp_ovf, eovf);
    held = rsp_data;
    if (stall > 0) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk("stall_valid", rsp_valid, 1);
        chk("stall_data", rsp_data, held);
        chk("stall_ready", {30'd0, req1_ready, req0_ready}, 0);
        chk("stall_count", op_count, ecnt - 16'd1);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    chk("count", op_count, ecnt);
    chk("rsp_drop", rsp_valid, 0);
  endtask

  initial begin
    logic [7:0] cdata;
    int n;
    do_reset();
    #1;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_count", op_count, 0);
    chk("rst_data", rsp_data, 0);
    single(1'b0, 2'd3, 8'd4, 8'd4, 8'd8, 1'b0, 0, 16'd1);
    single(1'b1, 2'd3, 8'hF0, 8'h20, 8'h10, 1'b1, 0, 16'd2);
    single(1'b0, 2'd0, 8'hF0, 8'h3C, 8'h30, 1'b0, 0, 16'd3);
    single(1'b1, 2'd1, 8'hA0, 8'h05, 8'hA5, 1'b0, 5, 16'd4);
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 2'd3; req0_a = 8'd4; req0_b = 8'd4;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", rsp_valid, 0);
    chk("arst_id", rsp_id, 0);
    chk("arst_data", rsp_data, 0);
    chk("arst_ovf", rsp_ovf, 0);
    chk("arst_count", op_count, 0);
    chk("arst_ready", {30'd0, req1_ready, req0_ready}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("arst_idle_ready", req0_ready, 1);
    req0_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      single(k[0], 2'd2, 8'hFF, 8'h0F, 8'hF0, 1'b0, 0, 16'(k + 1));
      chk("sat_count", sat_cnt, k < 3 ? k + 1 : 3);
    end
    do_reset();
    req0_valid = 1'b1; req0_op = 2'd3; req0_a = 8'd1; req0_b = 8'd2;
    req1_valid = 1'b1; req1_op = 2'd2; req1_a = 8'hFF; req1_b = 8'h0F;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
      chk("cont_timeout", n < 10, 1);
`ifdef MCPU_ALU_ARB_RR_EN
      chk("cont_id", rsp_id, k[0]);
      cdata = k[0] ? 8'hF0 : 8'h03;
`else
      chk("cont_id", rsp_id, 0);
      cdata = 8'h03;
`endif
      chk("cont_data", rsp_data, cdata);
      if (k == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      @(negedge clk);
    end
    chk("cont_count", op_count, 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
